// File: rtl/ps2_key_encoder_pkg.sv
// Shared constants, FSM state encoding and key event record for the PS/2 set-2 encoder.
// Imported by the encoder top and by its optional event FIFO.
package ps2_key_pkg;

   localparam logic [7:0] SC_EXT         = 8'hE0;
   localparam logic [7:0] SC_REL         = 8'hF0;
   localparam logic [7:0] SC_PAUSE       = 8'hE1;
   localparam logic [7:0] PAUSE_CODE     = 8'h77;
   localparam int         PAUSE_LEN      = 7;
   localparam int         EVT_FIFO_DEPTH = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_EXT,
      ST_REL,
      ST_EXT_REL,
      ST_PAUSE
   } state_t;

   typedef struct packed {
      logic       pressed;
      logic       ext;
      logic [7:0] code;
   } key_evt_t;

   function automatic logic is_prefix(input logic [7:0] b);
      return (b == SC_EXT) || (b == SC_REL) || (b == SC_PAUSE);
   endfunction

endpackage

// File: rtl/ps2_key_encoder_if.sv
// Byte-stream input handshake plus toggle-format key event outputs of the encoder.
// The encoder takes the slave modport; the byte source / consumer side takes master.
interface ps2_key_encoder_if;

   logic [7:0]  byte_data;
   logic        byte_valid;
   logic        byte_ready;
   logic [10:0] ps2_key;
   logic        key_strobe;
   logic        seq_error;

   modport master (
      output byte_data, byte_valid,
      input  byte_ready, ps2_key, key_strobe, seq_error
   );

   modport slave (
      input  byte_data, byte_valid,
      output byte_ready, ps2_key, key_strobe, seq_error
   );

endinterface

// File: rtl/ps2_key_encoder_evt_fifo.sv
// Small synchronous FIFO for parsed key events; zero-latency head, push accepted on full when popping.
// Only used when PS2_KEY_ENCODER_FIFO_EN is defined.
module ps2_evt_fifo
   import ps2_key_pkg::*;
#(
   parameter int DEPTH = EVT_FIFO_DEPTH,
   parameter int W     = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  logic [W-1:0] din_i,
   input  logic         pop_i,
   output logic [W-1:0] dout_o,
   output logic         full_o,
   output logic         empty_o
);

   localparam int AW = (DEPTH < 2) ? 1 : $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [AW:0]   cnt_q;
   logic          do_push, do_pop;

   assign full_o  = (cnt_q == (AW+1)'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   assign dout_o  = mem_q[rd_q];

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= din_i;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (do_pop)  rd_q <= rd_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/ps2_key_encoder.sv
// PS/2 set-2 byte stream to 11-bit toggle key event bus with E0/F0/E1 parsing and event holdoff.
// Define PS2_KEY_ENCODER_FIFO_EN to buffer events in a 4-entry FIFO instead of stalling on holdoff.
module ps2_key_encoder
   import ps2_key_pkg::*;
#(
   parameter int HOLDOFF = 16
) (
   input  logic clk_sys,
   input  logic reset,
   ps2_key_encoder_if.slave bus
);

   localparam int              HW      = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);
   localparam logic [HW-1:0]   HOLD_LD = HW'(HOLDOFF);

   state_t        state_q, state_d;
   logic [2:0]    pause_q, pause_d;
   logic [HW-1:0] hold_q;
   logic [10:0]   key_q;
   logic          strobe_q, err_q;

   logic          ready_w, acc, evt_vld, err_d, emit;
   key_evt_t      evt, emit_evt;

   assign acc = bus.byte_valid && ready_w;

   always_comb begin
      state_d     = state_q;
      pause_d     = pause_q;
      evt_vld     = 1'b0;
      err_d       = 1'b0;
      evt.pressed = 1'b1;
      evt.ext     = 1'b0;
      evt.code    = bus.byte_data;
      if (acc) begin
         unique case (state_q)
            ST_IDLE: begin
               if (bus.byte_data == SC_EXT)        state_d = ST_EXT;
               else if (bus.byte_data == SC_REL)   state_d = ST_REL;
               else if (bus.byte_data == SC_PAUSE) begin
                  state_d = ST_PAUSE;
                  pause_d = 3'(PAUSE_LEN);
               end else evt_vld = 1'b1;
            end
            ST_EXT: begin
               if (bus.byte_data == SC_REL) state_d = ST_EXT_REL;
               else if (bus.byte_data == SC_EXT) err_d = 1'b1;
               else if (bus.byte_data == SC_PAUSE) begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  evt_vld = 1'b1;
                  evt.ext = 1'b1;
                  state_d = ST_IDLE;
               end
            end
            ST_REL, ST_EXT_REL: begin
               state_d = ST_IDLE;
               if (is_prefix(bus.byte_data)) err_d = 1'b1;
               else begin
                  evt_vld     = 1'b1;
                  evt.pressed = 1'b0;
                  evt.ext     = (state_q == ST_EXT_REL);
               end
            end
            ST_PAUSE: begin
               // Byte content is irrelevant inside the pause sequence; only its length matters.
               pause_d = pause_q - 1'b1;
               if (pause_q == 3'd1) begin
                  evt_vld  = 1'b1;
                  evt.ext  = 1'b1;
                  evt.code = PAUSE_CODE;
                  state_d  = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

`ifdef PS2_KEY_ENCODER_FIFO_EN
   key_evt_t head;
   logic     fifo_full, fifo_empty;

   ps2_evt_fifo #(.DEPTH(EVT_FIFO_DEPTH), .W(10)) u_evt_fifo (
      .clk     (clk_sys),
      .rst     (reset),
      .push_i  (evt_vld),
      .din_i   (evt),
      .pop_i   (emit),
      .dout_o  (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign ready_w  = !fifo_full;
   assign emit     = (hold_q == '0) && !fifo_empty;
   assign emit_evt = head;
`else
   // Without buffering, every byte (prefixes too) waits out the holdoff, so an event can always emit.
   assign ready_w  = (hold_q == '0);
   assign emit     = evt_vld;
   assign emit_evt = evt;
`endif

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         pause_q  <= '0;
         hold_q   <= '0;
         key_q    <= '0;
         strobe_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         pause_q  <= pause_d;
         strobe_q <= emit;
         err_q    <= err_d;
         if (emit) key_q <= {~key_q[10], emit_evt};
         if (emit)                hold_q <= HOLD_LD;
         else if (hold_q != '0)   hold_q <= hold_q - 1'b1;
      end
   end

   assign bus.byte_ready = ready_w;
   assign bus.ps2_key    = key_q;
   assign bus.key_strobe = strobe_q;
   assign bus.seq_error  = err_q;

endmodule

// File: tb/tb_ps2_key_encoder.sv
// Self-checking bench for ps2_key_encoder: directed scan-code scenarios plus random byte streams
// scored against a sequence-level reference model of events, toggles and event timing.
module tb_ps2_key_encoder;

   localparam int H = 16;
`ifdef PS2_KEY_ENCODER_FIFO_EN
   localparam int LAT  = 2;
   localparam bit FIFO = 1'b1;
`else
   localparam int LAT  = 1;
   localparam bit FIFO = 1'b0;
`endif

   logic clk_sys = 1'b0;
   logic reset   = 1'b0;

   ps2_key_encoder_if bus();

   ps2_key_encoder #(.HOLDOFF(H)) dut (
      .clk_sys (clk_sys),
      .reset   (reset),
      .bus     (bus)
   );

   always #5 clk_sys = ~clk_sys;

   int errors = 0;
   int checks = 0;
   int ncyc   = 0;
   int ready_low = 0;

   logic [7:0]  acc_b[$];
   int          acc_c[$];
   logic [10:0] obs_key[$];
   int          obs_cyc[$];
   int          err_cyc[$];
   logic [10:0] exp_key[$];
   int          exp_cyc[$];
   int          exp_err[$];
   logic [7:0]  pend[$];
   logic        tog;
   int          prev;

   // Observe at the falling edge: a transfer seen here completes on the next rising edge.
   always @(negedge clk_sys) begin
      ncyc++;
      if (!reset) begin
         if (bus.byte_valid && bus.byte_ready) begin
            acc_b.push_back(bus.byte_data);
            acc_c.push_back(ncyc);
         end
         if (bus.key_strobe) begin
            obs_key.push_back(bus.ps2_key);
            obs_cyc.push_back(ncyc);
         end
         if (bus.seq_error) err_cyc.push_back(ncyc);
         if (!bus.byte_ready) ready_low++;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic model_clear();
      pend.delete(); acc_b.delete(); acc_c.delete();
      obs_key.delete(); obs_cyc.delete(); err_cyc.delete();
      exp_key.delete(); exp_cyc.delete(); exp_err.delete();
      tog  = 1'b0;
      prev = -1000;
   endtask

   task automatic model_emit(input bit pr, input bit ex, input logic [7:0] code, input int c);
      int t;
      tog = ~tog;
      exp_key.push_back({tog, pr, ex, code});
      t = (c + LAT > prev + H + 1) ? c + LAT : prev + H + 1;
      exp_cyc.push_back(t);
      prev = t;
   endtask

   // Interprets accepted bytes as whole scan-code sequences: [x], [E0 x], [F0 x], [E0 F0 x], E1+7.
   task automatic model_run();
      logic [7:0] b;
      int c;
      for (int i = 0; i < acc_b.size(); i++) begin
         b = acc_b[i];
         c = acc_c[i];
         if (pend.size() > 0 && pend[0] == 8'hE1) begin
            pend.push_back(b);
            if (pend.size() == 8) begin
               model_emit(1'b1, 1'b1, 8'h77, c);
               pend.delete();
            end
         end else if (b == 8'hE0 || b == 8'hF0 || b == 8'hE1) begin
            if (pend.size() == 0) pend.push_back(b);
            else if (pend.size() == 1 && pend[0] == 8'hE0 && b == 8'hF0) pend.push_back(b);
            else begin
               exp_err.push_back(c + 1);
               if (!(pend.size() == 1 && pend[0] == 8'hE0 && b == 8'hE0)) pend.delete();
            end
         end else begin
            model_emit(!(pend.size() > 0 && pend[pend.size()-1] == 8'hF0),
                       pend.size() > 0 && pend[0] == 8'hE0, b, c);
            pend.delete();
         end
      end
      acc_b.delete();
      acc_c.delete();
   endtask

   task automatic send(input logic [7:0] b);
      bus.byte_valid = 1'b1;
      bus.byte_data  = b;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk_sys);
         if (bus.byte_ready) begin
            @(posedge clk_sys); #1;
            return;
         end
      end
      checks++; errors++;
      $display("FAIL send_timeout: byte %h not accepted within 200 cycles", b);
      @(posedge clk_sys); #1;
   endtask

   task automatic idle(input int n);
      bus.byte_valid = 1'b0;
      repeat (n) @(posedge clk_sys);
      #1;
   endtask

   task automatic test_reset();
      bus.byte_valid = 1'b0;
      reset = 1'b1;
      repeat (2) @(posedge clk_sys);
      #1;
      checks++; if (bus.ps2_key !== 11'h000) begin errors++; $display("FAIL reset_key: got %h want 000", bus.ps2_key); end
      checks++; if (bus.key_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %b want 0", bus.key_strobe); end
      checks++; if (bus.seq_error !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus.seq_error); end
      checks++; if (bus.byte_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.byte_ready); end
      reset = 1'b0;
      model_clear();
      idle(2);
   endtask

   task automatic test_basic();
      test_reset();
      ready_low = 0;
      send(8'h1C);
      idle(H + 8);
      model_run();
      checks++; if (obs_key.size() != exp_key.size() || err_cyc.size() != exp_err.size()) begin errors++; $display("FAIL basic_count: got %0d ev %0d err want %0d ev %0d err", obs_key.size(), err_cyc.size(), exp_key.size(), exp_err.size()); end
      foreach (exp_key[i]) if (i < obs_key.size()) begin checks++; if (obs_key[i] !== exp_key[i] || obs_cyc[i] != exp_cyc[i]) begin errors++; $display("FAIL basic_evt%0d: got %h@%0d want %h@%0d", i, obs_key[i], obs_cyc[i], exp_key[i], exp_cyc[i]); end end
      checks++; if (bus.ps2_key !== 11'h61C) begin errors++; $display("FAIL basic_key: got %h want 61c", bus.ps2_key); end
      checks++; if (ready_low != (FIFO ? 0 : H)) begin errors++; $display("FAIL basic_stall: got %0d low cycles want %0d", ready_low, FIFO ? 0 : H); end
   endtask

   task automatic test_ext();
      test_reset();
      send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
      idle(H + 8);
      model_run();
      checks++; if (obs_key.size() != exp_key.size() || err_cyc.size() != exp_err.size()) begin errors++; $display("FAIL ext_count: got %0d ev %0d err want %0d ev %0d err", obs_key.size(), err_cyc.size(), exp_key.size(), exp_err.size()); end
      foreach (exp_key[i]) if (i < obs_key.size()) begin checks++; if (obs_key[i] !== exp_key[i] || obs_cyc[i] != exp_cyc[i]) begin errors++; $display("FAIL ext_evt%0d: got %h@%0d want %h@%0d", i, obs_key[i], obs_cyc[i], exp_key[i], exp_cyc[i]); end end
      checks++; if (bus.ps2_key !== 11'h175) begin errors++; $display("FAIL ext_key: got %h want 175", bus.ps2_key); end
      if (obs_cyc.size() >= 2) begin checks++; if (obs_cyc[1] - obs_cyc[0] < H + 1) begin errors++; $display("FAIL ext_spacing: got %0d want >= %0d", obs_cyc[1] - obs_cyc[0], H + 1); end end
   endtask

   task automatic test_seq_err();
      test_reset();
      send(8'hF0); send(8'hE0); send(8'h29);
      idle(H + 8);
      model_run();
      checks++; if (obs_key.size() != exp_key.size() || err_cyc.size() != 1) begin errors++; $display("FAIL seqerr_count: got %0d ev %0d err want %0d ev 1 err", obs_key.size(), err_cyc.size(), exp_key.size()); end
      foreach (exp_err[i]) if (i < err_cyc.size()) begin checks++; if (err_cyc[i] != exp_err[i]) begin errors++; $display("FAIL seqerr_time%0d: got %0d want %0d", i, err_cyc[i], exp_err[i]); end end
      foreach (exp_key[i]) if (i < obs_key.size()) begin checks++; if (obs_key[i] !== exp_key[i] || obs_cyc[i] != exp_cyc[i]) begin errors++; $display("FAIL seqerr_evt%0d: got %h@%0d want %h@%0d", i, obs_key[i], obs_cyc[i], exp_key[i], exp_cyc[i]); end end
      checks++; if (bus.ps2_key !== 11'h629) begin errors++; $display("FAIL seqerr_key: got %h want 629", bus.ps2_key); end
   endtask

   task automatic test_pause();
      logic [7:0] seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
      test_reset();
      foreach (seq[i]) send(seq[i]);
      idle(H + 8);
      model_run();
      checks++; if (obs_key.size() != 1 || err_cyc.size() != 0) begin errors++; $display("FAIL pause_count: got %0d ev %0d err want 1 ev 0 err", obs_key.size(), err_cyc.size()); end
      foreach (exp_key[i]) if (i < obs_key.size()) begin checks++; if (obs_key[i] !== exp_key[i] || obs_cyc[i] != exp_cyc[i]) begin errors++; $display("FAIL pause_evt%0d: got %h@%0d want %h@%0d", i, obs_key[i], obs_cyc[i], exp_key[i], exp_cyc[i]); end end
      checks++; if (bus.ps2_key !== 11'h777) begin errors++; $display("FAIL pause_key: got %h want 777", bus.ps2_key); end
   endtask

   task automatic test_reset_mid();
      test_reset();
      send(8'hE0);
      idle(1);
      test_reset();
      send(8'h6B);
      idle(H + 8);
      model_run();
      checks++; if (obs_key.size() != 1 || err_cyc.size() != 0) begin errors++; $display("FAIL rstmid_count: got %0d ev %0d err want 1 ev 0 err", obs_key.size(), err_cyc.size()); end
      checks++; if (bus.ps2_key !== 11'h66B) begin errors++; $display("FAIL rstmid_key: got %h want 66b", bus.ps2_key); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] seq [5] = '{8'h1C, 8'h1B, 8'h23, 8'h34, 8'h2D};
      test_reset();
      ready_low = 0;
      foreach (seq[i]) send(seq[i]);
      idle(6 * (H + 1) + 10);
      model_run();
      checks++; if (obs_key.size() != 5 || exp_key.size() != 5) begin errors++; $display("FAIL b2b_count: got %0d ev want 5", obs_key.size()); end
      foreach (exp_key[i]) if (i < obs_key.size()) begin checks++; if (obs_key[i] !== exp_key[i] || obs_cyc[i] != exp_cyc[i]) begin errors++; $display("FAIL b2b_evt%0d: got %h@%0d want %h@%0d", i, obs_key[i], obs_cyc[i], exp_key[i], exp_cyc[i]); end end
      if (FIFO) begin checks++; if (ready_low == 0) begin errors++; $display("FAIL b2b_fifo_full: got %0d ready-low cycles want > 0", ready_low); end end
   endtask

   task automatic test_random();
      int r;
      logic [7:0] b;
      test_reset();
      for (int n = 0; n < 250; n++) begin
         r = $urandom_range(0, 9);
         if (r == 0) b = 8'hE0;
         else if (r == 1) b = 8'hF0;
         else if (r == 2 && $urandom_range(0, 3) == 0) b = 8'hE1;
         else b = 8'($urandom_range(0, 8'hDF));
         send(b);
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 20));
      end
      idle(6 * (H + 1) + 10);
      model_run();
      checks++; if (obs_key.size() != exp_key.size() || err_cyc.size() != exp_err.size()) begin errors++; $display("FAIL rand_count: got %0d ev %0d err want %0d ev %0d err", obs_key.size(), err_cyc.size(), exp_key.size(), exp_err.size()); end
      foreach (exp_key[i]) if (i < obs_key.size()) begin checks++; if (obs_key[i] !== exp_key[i] || obs_cyc[i] != exp_cyc[i]) begin errors++; $display("FAIL rand_evt%0d: got %h@%0d want %h@%0d", i, obs_key[i], obs_cyc[i], exp_key[i], exp_cyc[i]); end end
      foreach (exp_err[i]) if (i < err_cyc.size()) begin checks++; if (err_cyc[i] != exp_err[i]) begin errors++; $display("FAIL rand_err%0d: got %0d want %0d", i, err_cyc[i], exp_err[i]); end end
   endtask

   initial begin
      bus.byte_valid = 1'b0;
      bus.byte_data  = 8'h00;
      @(posedge clk_sys); #1;
      test_reset();
      test_basic();
      test_ext();
      test_seq_err();
      test_pause();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ps2_key_encoder.md
Name: ps2_key_encoder

Overview:
- Converts a raw PS/2 set-2 scan-code byte stream into the 11-bit toggle-format key event bus consumed by core keyboard decoders.
- Event bus format: bit10 = toggle, bit9 = pressed, bit8 = extended, bits7:0 = code.
- Sits on clk_sys between the byte source (HPS bridge or serial PS/2 receiver) and every `ps2_key` consumer.
- Parses E0/F0/E1 prefixes, enforces minimum event spacing and flags malformed sequences.

Parameters:
- HOLDOFF, 16: minimum clk_sys cycles between successive toggles of ps2_key[10]; 0 = back-to-back allowed.

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- byte_data  in  8  scan-code byte.
- byte_valid  in  1  byte_data valid.
- byte_ready  out  1  block accepts byte this cycle; transfer = byte_valid & byte_ready.
- ps2_key  out  11  {toggle, pressed, extended, code[7:0]}.
- key_strobe  out  1  one-cycle pulse coincident with each ps2_key update.
- seq_error  out  1  one-cycle pulse on malformed prefix sequence.

Behaviour:
- Reset values: ps2_key = 0, key_strobe = 0, seq_error = 0, FSM = IDLE, holdoff counter = 0, pause counter = 0.
- byte_ready = 1 out of reset, unless stalled as defined below.
- FSM states: IDLE, EXT, REL, EXT_REL, PAUSE. Transitions occur only on an accepted byte:
  - IDLE:
    - E0 -> EXT.
    - F0 -> REL.
    - E1 -> PAUSE, pause counter = 7.
    - Any other byte -> emit {pressed=1, ext=0, byte}, stay IDLE.
  - EXT:
    - F0 -> EXT_REL.
    - E0 -> seq_error, stay EXT.
    - E1 -> seq_error, go IDLE.
    - Other byte -> emit {pressed=1, ext=1, byte}, go IDLE.
  - REL:
    - E0, F0 or E1 -> seq_error, go IDLE, no emit.
    - Other byte -> emit {pressed=0, ext=0, byte}, go IDLE.
  - EXT_REL:
    - E0, F0 or E1 -> seq_error, go IDLE, no emit.
    - Other byte -> emit {pressed=0, ext=1, byte}, go IDLE.
  - PAUSE:
    - Each byte decrements the pause counter; content is ignored.
    - When the counter reaches 0, emit {pressed=1, ext=1, 8'h77} and go IDLE.
    - Pause produces no release event.
- Emit: ps2_key registered one cycle after the accepting edge; bit10 inverts, bits9:0 load, key_strobe = 1 for that cycle.
- Holdoff: each emit loads the counter with HOLDOFF, which decrements to 0. No emit may occur while the counter is non-zero.
- Stall (without FIFO): byte_ready = (holdoff == 0). Prefix bytes are also stalled, for simplicity.
- Spacing: two events are never closer than HOLDOFF+1 cycles, except HOLDOFF = 0, which gives a 1-cycle spacing.
- Counter width: $clog2(HOLDOFF+1), minimum 1.
- Reset mid-sequence: partial prefix discarded, toggle cleared, no strobe.
- byte_valid without byte_ready: byte_data must be held by the source; it is not sampled.

Optional Feature:
- Macro: PS2_KEY_ENCODER_FIFO_EN.
- Defined:
  - A 4-entry event FIFO of 10-bit {pressed, ext, code} entries sits between FSM and output.
  - byte_ready = !fifo_full.
  - The FSM parses at full rate; the FIFO head is emitted whenever holdoff == 0 and the FIFO is non-empty.
  - Simultaneous push and pop on a full FIFO is permitted.
  - Latency from the final byte to the ps2_key update is 2 cycles when the FIFO is empty and holdoff == 0.
- Undefined:
  - No FIFO; stall rule as in Behaviour.
  - Latency is 1 cycle.

Decomposition:
- Package ps2_key_pkg:
  - Constants SC_EXT = 8'hE0, SC_REL = 8'hF0, SC_PAUSE = 8'hE1, PAUSE_CODE = 8'h77, PAUSE_LEN = 7, EVT_FIFO_DEPTH = 4.
  - Enum typedef for FSM states.
  - Packed struct key_evt_t {pressed, ext, code}.
- Sub-module ps2_evt_fifo (synchronous, depth EVT_FIFO_DEPTH, width 10): instantiated only under PS2_KEY_ENCODER_FIFO_EN.

Test Plan:
- Reset; send 1C -> one cycle later ps2_key = 11'h61C (toggle=1, pressed=1), key_strobe pulses once, byte_ready stays low for 16 cycles.
- Send E0,75 then E0,F0,75 -> ps2_key = 11'h775, then 11'h175 (toggle back to 0); the two strobes are at least 17 cycles apart.
- Send F0,E0 -> seq_error pulse on E0, no strobe; then send 29 -> ps2_key = 11'h629.
- Send E1,14,77,E1,F0,14,F0,77 -> exactly one event, ps2_key = 11'h777, after the 8th byte; no event on intermediate bytes.
- Assert reset after E0 is accepted; release; send 6B -> ps2_key = 11'h66B (ext=0, toggle=1).
- FIFO_EN with HOLDOFF = 16, byte_valid held high on 1C,1B,23,34,2D -> byte_ready drops when the FIFO holds 4 entries; all five events emitted in order, spaced 17 cycles, with no loss.
